dac_spi_serializer: RTL and testbench

Parametrised SPI serializer for multi-channel DAC chains (DAC8568-class and wider/narrower parts). It accepts words from the pulse-sequencer/host side through a small internal FIFO. Each word is shifted MSB-first on a self-generated SCLK with configurable rate, word width and inter-frame gap. Its behaviour extends the single-word bitbang DAC driver with queuing, clock division, a minimum SYNC-high gap, and overflow reporting.

---
 rtl/dac_spi_serializer.sv | 164 ++++++++++++++++
 tb/tb_dac_spi_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_serializer.sv
// SPI serializer for DAC chains: queued words shifted MSB-first on a divided SCLK,
// with a minimum SYNC-high gap between frames and sticky overflow on dropped writes.
module dac_spi_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  wr_en,
  input  logic                  clear_overflow,
  output logic                  busy,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  dac_sclk,
  output logic                  dac_sync,
  output logic                  dac_din
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t state, state_nxt;

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  push, pop;

  logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]         bitcnt, bitcnt_nxt;
  logic                  phase, phase_nxt;
  logic [7:0]            divcnt, div_nxt;
  logic [7:0]            gapcnt, gap_nxt;
  logic                  sclk_nxt, sync_nxt, din_nxt;

  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + 1'b1;
      pop && !push: count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

  // Full test uses the registered flag, so a same-cycle pop cannot rescue a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= count_nxt == CW'(FIFO_DEPTH);
      empty <= count_nxt == '0;
      if (wr_en && full)       overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    phase_nxt  = phase;
    div_nxt    = divcnt;
    gap_nxt    = gapcnt;
    sclk_nxt   = dac_sclk;
    sync_nxt   = dac_sync;
    din_nxt    = dac_din;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          shreg_nxt  = mem[rptr];
          din_nxt    = mem[rptr][WORD_WIDTH-1];
          bitcnt_nxt = BW'(WORD_WIDTH);
          phase_nxt  = 1'b0;
          div_nxt    = '0;
          sclk_nxt   = 1'b1;
          sync_nxt   = 1'b0;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (divcnt != DIV_LAST) begin
          div_nxt = divcnt + 1'b1;
        end else begin
          div_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
            sclk_nxt  = 1'b0;
          end else if (bitcnt > BW'(1)) begin
            shreg_nxt  = shreg << 1;
            din_nxt    = shreg[WORD_WIDTH-2];
            bitcnt_nxt = bitcnt - 1'b1;
            phase_nxt  = 1'b0;
            sclk_nxt   = 1'b1;
          end else begin
            sync_nxt  = 1'b1;
            din_nxt   = 1'b0;
            gap_nxt   = '0;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gapcnt == GAP_LAST) state_nxt = IDLE;
        else gap_nxt = gapcnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      phase    <= 1'b0;
      divcnt   <= '0;
      gapcnt   <= '0;
      dac_sclk <= 1'b0;
      dac_sync <= 1'b1;
      dac_din  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bitcnt   <= bitcnt_nxt;
      phase    <= phase_nxt;
      divcnt   <= div_nxt;
      gapcnt   <= gap_nxt;
      dac_sclk <= sclk_nxt;
      dac_sync <= sync_nxt;
      dac_din  <= din_nxt;
      busy     <= push || !empty || (state != IDLE);
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench: default instance plus a CLK_DIV=3/24-bit/GAP=5 instance,
// frames decoded from SCLK/SYNC/DIN sampled on the falling clk edge.
module tb_dac_spi_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] data1 = '0;
  logic        wr1 = 1'b0, clr1 = 1'b0;
  logic        busy1, full1, empty1, ovf1, sclk1, sync1, din1;

  logic [23:0] data3 = '0;
  logic        wr3 = 1'b0, clr3 = 1'b0;
  logic        busy3, full3, empty3, ovf3, sclk3, sync3, din3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_spi_serializer u_dut (
    .clk(clk), .reset(reset), .data(data1), .wr_en(wr1),
    .clear_overflow(clr1), .busy(busy1), .full(full1), .empty(empty1),
    .overflow(ovf1), .dac_sclk(sclk1), .dac_sync(sync1), .dac_din(din1)
  );

  dac_spi_serializer #(
    .WORD_WIDTH(24), .FIFO_DEPTH(4), .CLK_DIV(3), .GAP_CYCLES(5)
  ) u_dut3 (
    .clk(clk), .reset(reset), .data(data3), .wr_en(wr3),
    .clear_overflow(clr3), .busy(busy3), .full(full3), .empty(empty3),
    .overflow(ovf3), .dac_sclk(sclk3), .dac_sync(sync3), .dac_din(din3)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic f_sync(input bit s);
    return s ? sync3 : sync1;
  endfunction
  function automatic logic f_sclk(input bit s);
    return s ? sclk3 : sclk1;
  endfunction
  function automatic logic f_din(input bit s);
    return s ? din3 : din1;
  endfunction
  function automatic logic f_empty(input bit s);
    return s ? empty3 : empty1;
  endfunction

  task automatic wr(input logic [31:0] v);
    data1 = v;
    wr1   = 1'b1;
    @(negedge clk);
    wr1   = 1'b0;
  endtask

  task automatic wait_sync(input logic lvl, input int lim, input string tag);
    int t = 0;
    while (sync1 !== lvl && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(t >= lim), 64'd0);
  endtask

  // Decodes one frame; gap = number of SYNC-high samples before it.
  task automatic capture(input bit sel, input int div,
                         output logic [63:0] w, output int low,
                         output int rises, output int bad,
                         output int gap, output logic e0);
    int   run;
    logic prev, s;
    logic tmo;
    w = '0; low = 0; rises = 0; bad = 0; gap = 0; e0 = 1'bx;
    tmo = 1'b0; run = 0; prev = 1'b0;
    while (f_sync(sel) !== 1'b0 && gap < 2000) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 2000) tmo = 1'b1;
    e0 = f_empty(sel);
    while (!tmo && f_sync(sel) === 1'b0) begin
      low++;
      s = f_sclk(sel);
      if (s != prev) begin
        if (low > 1 && run != div) bad++;
        if (s) rises++;
        else   w = {w[62:0], f_din(sel)};
        run = 1;
      end else begin
        run++;
      end
      prev = s;
      if (low > 5000) tmo = 1'b1;
      @(negedge clk);
    end
    if (!tmo && run != div) bad++;
    chk("capture_timeout", 64'(tmo), 64'd0);
  endtask

  logic [63:0] w;
  int          low, rises, bad, gap;
  logic        e0;
  logic [31:0] exp_q [4];
  logic [31:0] wrap_q [15];
  int          act, bits, t;
  logic        prv;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_full", 64'(full1), 64'd0);
    chk("rst_empty", 64'(empty1), 64'd1);
    chk("rst_ovf", 64'(ovf1), 64'd0);
    chk("rst_sclk", 64'(sclk1), 64'd0);
    chk("rst_sync", 64'(sync1), 64'd1);
    chk("rst_din", 64'(din1), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // single word, default parameters
    wr(32'h1234_5678);
    chk("w1_empty", 64'(empty1), 64'd0);
    chk("w1_busy", 64'(busy1), 64'd1);
    chk("w1_sync", 64'(sync1), 64'd1);
    capture(1'b0, 1, w, low, rises, bad, gap, e0);
    chk("w1_word", w, 64'h1234_5678);
    chk("w1_low", 64'(low), 64'd64);
    chk("w1_rises", 64'(rises), 64'd32);
    chk("w1_phase", 64'(bad), 64'd0);
    chk("w1_end_sclk", 64'(sclk1), 64'd0);
    chk("w1_end_din", 64'(din1), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("w1_busy_gap", 64'(busy1), 64'd1);
    @(negedge clk);
    chk("w1_busy_off", 64'(busy1), 64'd0);

    // back-to-back queue fill plus overflow while full
    exp_q = '{32'hB000_000B, 32'hC0C0_C0C0, 32'hD00D_1234, 32'hE1E2_E3E4};
    wr(32'hAAAA_5555);
    wait_sync(1'b0, 20, "b2b_start");
    foreach (exp_q[i]) wr(exp_q[i]);
    chk("b2b_full", 64'(full1), 64'd1);
    wr(32'hDEAD_BEEF);
    chk("ovf_set", 64'(ovf1), 64'd1);
    chk("ovf_full", 64'(full1), 64'd1);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("ovf_clr", 64'(ovf1), 64'd0);
    wait_sync(1'b1, 200, "b2b_a_end");
    for (int i = 0; i < 4; i++) begin
      capture(1'b0, 1, w, low, rises, bad, gap, e0);
      chk("b2b_word", w, 64'(exp_q[i]));
      chk("b2b_gap", 64'(gap), 64'd3);
      if (i >= 2) chk("b2b_empty", 64'(e0), 64'(i == 3));
    end

    // write while full in the same cycle IDLE pops
    exp_q = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    wr(32'hF0F0_0000);
    wait_sync(1'b0, 20, "pop_start");
    foreach (exp_q[i]) wr(exp_q[i]);
    wait_sync(1'b1, 200, "pop_f0_end");
    @(negedge clk);
    @(negedge clk);
    wr(32'hBAD0_BAD0);
    chk("pop_ovf", 64'(ovf1), 64'd1);
    chk("pop_full", 64'(full1), 64'd0);
    chk("pop_sync", 64'(sync1), 64'd0);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    wait_sync(1'b1, 200, "pop_f1_end");
    for (int i = 1; i < 4; i++) begin
      capture(1'b0, 1, w, low, rises, bad, gap, e0);
      chk("pop_word", w, 64'(exp_q[i]));
    end
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (!sync1) act++;
    end
    chk("pop_no_extra", 64'(act), 64'd0);
    chk("pop_drained", 64'(empty1), 64'd1);

    // second instance: CLK_DIV=3, 24-bit, GAP=5
    data3 = 24'hA5C3F0;
    wr3 = 1'b1;
    @(negedge clk);
    wr3 = 1'b0;
    capture(1'b1, 3, w, low, rises, bad, gap, e0);
    chk("d3_word", w, 64'hA5C3F0);
    chk("d3_low", 64'(low), 64'd144);
    chk("d3_rises", 64'(rises), 64'd24);
    chk("d3_phase", 64'(bad), 64'd0);

    // reset mid-frame with two words queued
    wr(32'h0F0F_0F0F);
    wr(32'h1357_9BDF);
    wr(32'h2468_ACE0);
    wait_sync(1'b0, 20, "rst_frame");
    bits = 0; t = 0; prv = sclk1;
    while (bits < 10 && t < 200) begin
      @(negedge clk);
      t++;
      if (prv && !sclk1) bits++;
      prv = sclk1;
    end
    chk("rst_bits_tmo", 64'(t >= 200), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_sync", 64'(sync1), 64'd1);
    chk("mid_sclk", 64'(sclk1), 64'd0);
    chk("mid_din", 64'(din1), 64'd0);
    chk("mid_empty", 64'(empty1), 64'd1);
    chk("mid_busy", 64'(busy1), 64'd0);
    reset = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (sclk1 || !sync1) act++;
    end
    chk("mid_quiet", 64'(act), 64'd0);

    // wrap-around: 15 words paced at the frame rate
    foreach (wrap_q[i]) wrap_q[i] = 32'hC0DE_0000 ^ (32'h0103_0507 * (i + 1));
    fork
      begin
        foreach (wrap_q[i]) begin
          wr(wrap_q[i]);
          repeat (66) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 15; i++) begin
          capture(1'b0, 1, w, low, rises, bad, gap, e0);
          chk("wrap_word", w, 64'(wrap_q[i]));
        end
      end
    join
    chk("wrap_ovf", 64'(ovf1), 64'd0);
    repeat (5) @(negedge clk);
    chk("wrap_empty", 64'(empty1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
